// File: rtl/emern_pixel_core_multi.sv
// N-polygon pixel shader stage: per-pixel coverage test against NUM_POLY triangles,
// nearest-depth resolve, 2-stage registered pipeline with valid tracking.

module tt_um_emern_raster_core (
  input  logic [9:0] px,
  input  logic [8:0] py,
  input  logic [9:0] x0,
  input  logic [8:0] y0,
  input  logic [9:0] x1,
  input  logic [8:0] y1,
  input  logic [9:0] x2,
  input  logic [8:0] y2,
  output logic       hit
);

  // Edge function (b-a) x (c-a); sign tells which side of edge a->b point c lies on.
  function automatic logic signed [24:0] edge_fn(
    input logic [9:0] ax, input logic [8:0] ay,
    input logic [9:0] bx, input logic [8:0] by,
    input logic [9:0] cx, input logic [8:0] cy
  );
    logic signed [11:0] dx_ab, dy_ab, dx_ac, dy_ac;
    logic signed [24:0] p_a, p_b;
    dx_ab = $signed({2'b00, bx}) - $signed({2'b00, ax});
    dy_ab = $signed({3'b000, by}) - $signed({3'b000, ay});
    dx_ac = $signed({2'b00, cx}) - $signed({2'b00, ax});
    dy_ac = $signed({3'b000, cy}) - $signed({3'b000, ay});
    p_a = 25'(dx_ab) * 25'(dy_ac);
    p_b = 25'(dy_ab) * 25'(dx_ac);
    return p_a - p_b;
  endfunction

  logic signed [24:0] e0, e1, e2, area;
  logic all_pos, all_neg;

  always_comb begin
    e0      = edge_fn(x0, y0, x1, y1, px, py);
    e1      = edge_fn(x1, y1, x2, y2, px, py);
    e2      = edge_fn(x2, y2, x0, y0, px, py);
    area    = edge_fn(x0, y0, x1, y1, x2, y2);
    all_pos = (e0 >= 0) && (e1 >= 0) && (e2 >= 0);
    all_neg = (e0 <= 0) && (e1 <= 0) && (e2 <= 0);
    // Edges are inclusive; zero-area triangles never cover anything.
    hit     = (area != 0) && (all_pos || all_neg);
  end

endmodule

module emern_pixel_core_multi #(
  parameter int NUM_POLY  = 2,
  parameter int DEPTH_W   = 3,
  parameter int COORD_MUL = 10,
  parameter int COLOR_W   = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pix_valid,
  input  logic [8:0]                    pixel_row,
  input  logic [9:0]                    pixel_col,
  input  logic [NUM_POLY-1:0]           poly_en,
  input  logic [COLOR_W-1:0]            background,
  input  logic [NUM_POLY*COLOR_W-1:0]   poly_color,
  input  logic [NUM_POLY*7-1:0]         v0_x,
  input  logic [NUM_POLY*7-1:0]         v1_x,
  input  logic [NUM_POLY*7-1:0]         v2_x,
  input  logic [NUM_POLY*6-1:0]         v0_y,
  input  logic [NUM_POLY*6-1:0]         v1_y,
  input  logic [NUM_POLY*6-1:0]         v2_y,
  input  logic [NUM_POLY*DEPTH_W-1:0]   poly_depth,
  output logic [COLOR_W-1:0]            pixel_out,
  output logic                          pix_valid_out,
  output logic                          hit,
  output logic [$clog2(NUM_POLY)-1:0]   hit_idx
);

  localparam int IDX_W = $clog2(NUM_POLY);

  // Constant-multiplier expansion into shifted adds; overflow truncates by design.
  function automatic logic [9:0] scale_x(input logic [6:0] v);
    logic [9:0] acc;
    acc = '0;
    for (int b = 0; b < 10; b++)
      if (COORD_MUL[b]) acc = acc + ({3'b000, v} << b);
    return acc;
  endfunction

  function automatic logic [8:0] scale_y(input logic [5:0] v);
    logic [8:0] acc;
    acc = '0;
    for (int b = 0; b < 9; b++)
      if (COORD_MUL[b]) acc = acc + ({3'b000, v} << b);
    return acc;
  endfunction

  logic [NUM_POLY-1:0] raw_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_POLY; gi++) begin : g_poly
      tt_um_emern_raster_core u_raster (
        .px  (pixel_col),
        .py  (pixel_row),
        .x0  (scale_x(v0_x[gi*7 +: 7])),
        .y0  (scale_y(v0_y[gi*6 +: 6])),
        .x1  (scale_x(v1_x[gi*7 +: 7])),
        .y1  (scale_y(v1_y[gi*6 +: 6])),
        .x2  (scale_x(v2_x[gi*7 +: 7])),
        .y2  (scale_y(v2_y[gi*6 +: 6])),
        .hit (raw_hit[gi])
      );
    end
  endgenerate

  logic [NUM_POLY-1:0]         hit1_reg;
  logic [NUM_POLY*COLOR_W-1:0] color1_reg;
  logic [NUM_POLY*DEPTH_W-1:0] depth1_reg;
  logic [COLOR_W-1:0]          bg1_reg;
  logic                        valid1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit1_reg   <= '0;
      color1_reg <= '0;
      depth1_reg <= '0;
      bg1_reg    <= '0;
      valid1_reg <= 1'b0;
    end else begin
      hit1_reg   <= raw_hit & poly_en;
      color1_reg <= poly_color;
      depth1_reg <= poly_depth;
      bg1_reg    <= background;
      valid1_reg <= pix_valid;
    end
  end

  logic               best_found;
  logic [IDX_W-1:0]   best_idx;
  logic [DEPTH_W-1:0] best_depth;
  logic [COLOR_W-1:0] best_color;
  logic [COLOR_W-1:0] pixel_next;
  logic               hit_next;
  logic [IDX_W-1:0]   hit_idx_next;

  always_comb begin
    best_found = 1'b0;
    best_idx   = '0;
    best_depth = '0;
    best_color = '0;
    // Strict less-than keeps the lowest index on depth ties.
    for (int i = 0; i < NUM_POLY; i++) begin
      if (hit1_reg[i] && (!best_found || depth1_reg[i*DEPTH_W +: DEPTH_W] < best_depth)) begin
        best_found = 1'b1;
        best_idx   = IDX_W'(i);
        best_depth = depth1_reg[i*DEPTH_W +: DEPTH_W];
        best_color = color1_reg[i*COLOR_W +: COLOR_W];
      end
    end

    pixel_next   = '0;
    hit_next     = 1'b0;
    hit_idx_next = '0;
    if (valid1_reg) begin
      if (best_found) begin
        pixel_next   = best_color;
        hit_next     = 1'b1;
        hit_idx_next = best_idx;
      end else begin
        pixel_next   = bg1_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out     <= '0;
      pix_valid_out <= 1'b0;
      hit           <= 1'b0;
      hit_idx       <= '0;
    end else begin
      pixel_out     <= pixel_next;
      pix_valid_out <= valid1_reg;
      hit           <= hit_next;
      hit_idx       <= hit_idx_next;
    end
  end

endmodule

// File: tb/tb_emern_pixel_core_multi.sv
// Directed bench for emern_pixel_core_multi: a 2-polygon and a 4-polygon instance
// driven from shared pixel coordinates, checked against hand-computed results.

module tb_emern_pixel_core_multi;

  logic       clk;
  logic       rst_n;
  logic       pix_valid;
  logic [8:0] pixel_row;
  logic [9:0] pixel_col;

  // 2-polygon instance
  logic [1:0]  poly_en;
  logic [5:0]  background;
  logic [11:0] poly_color;
  logic [13:0] v0_x, v1_x, v2_x;
  logic [11:0] v0_y, v1_y, v2_y;
  logic [5:0]  poly_depth;
  logic [5:0]  pixel_out;
  logic        pix_valid_out;
  logic        hit;
  logic [0:0]  hit_idx;

  // 4-polygon instance
  logic [3:0]  poly_en4;
  logic [5:0]  background4;
  logic [23:0] poly_color4;
  logic [27:0] v0_x4, v1_x4, v2_x4;
  logic [23:0] v0_y4, v1_y4, v2_y4;
  logic [11:0] poly_depth4;
  logic [5:0]  pixel_out4;
  logic        pix_valid_out4;
  logic        hit4;
  logic [1:0]  hit_idx4;

  int checks = 0;
  int errors = 0;

  emern_pixel_core_multi #(.NUM_POLY(2)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid),
    .pixel_row(pixel_row), .pixel_col(pixel_col),
    .poly_en(poly_en), .background(background), .poly_color(poly_color),
    .v0_x(v0_x), .v1_x(v1_x), .v2_x(v2_x),
    .v0_y(v0_y), .v1_y(v1_y), .v2_y(v2_y),
    .poly_depth(poly_depth),
    .pixel_out(pixel_out), .pix_valid_out(pix_valid_out),
    .hit(hit), .hit_idx(hit_idx)
  );

  emern_pixel_core_multi #(.NUM_POLY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid),
    .pixel_row(pixel_row), .pixel_col(pixel_col),
    .poly_en(poly_en4), .background(background4), .poly_color(poly_color4),
    .v0_x(v0_x4), .v1_x(v1_x4), .v2_x(v2_x4),
    .v0_y(v0_y4), .v1_y(v1_y4), .v2_y(v2_y4),
    .poly_depth(poly_depth4),
    .pixel_out(pixel_out4), .pix_valid_out(pix_valid_out4),
    .hit(hit4), .hit_idx(hit_idx4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check2(input string tag, input logic [5:0] px, input logic v, input logic h, input logic idx);
    check({tag, ".pixel_out"}, 32'(pixel_out), 32'(px));
    check({tag, ".pix_valid_out"}, 32'(pix_valid_out), 32'(v));
    check({tag, ".hit"}, 32'(hit), 32'(h));
    check({tag, ".hit_idx"}, 32'(hit_idx), 32'(idx));
    $display("txn %-14s pixel_out=%h valid=%b hit=%b idx=%0d", tag, pixel_out, pix_valid_out, hit, hit_idx);
  endtask

  task automatic check4(input string tag, input logic [5:0] px, input logic v, input logic h, input logic [1:0] idx);
    check({tag, ".pixel_out4"}, 32'(pixel_out4), 32'(px));
    check({tag, ".pix_valid_out4"}, 32'(pix_valid_out4), 32'(v));
    check({tag, ".hit4"}, 32'(hit4), 32'(h));
    check({tag, ".hit_idx4"}, 32'(hit_idx4), 32'(idx));
    $display("txn %-14s pixel_out4=%h valid=%b hit=%b idx=%0d", tag, pixel_out4, pix_valid_out4, hit4, hit_idx4);
  endtask

  // Present one pixel for one cycle, then blank; leaves time at the negedge where its result is visible.
  task automatic run_px(input logic [9:0] col, input logic [8:0] row, input logic v);
    @(negedge clk);
    pixel_col = col;
    pixel_row = row;
    pix_valid = v;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
  endtask

  // Streaming table: coords, valid, expected results for both instances.
  logic [9:0] s_col   [4] = '{10'd20, 10'd80, 10'd80, 10'd50};
  logic [8:0] s_row   [4] = '{9'd20, 9'd80, 9'd80, 9'd50};
  logic       s_vld   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [5:0] e2_px   [4] = '{6'h03, 6'h00, 6'h0C, 6'h0C};
  logic       e2_hit  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic       e2_idx  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [5:0] e4_px   [4] = '{6'h30, 6'h00, 6'h0C, 6'h30};
  logic       e4_hit  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0] e4_idx  [4] = '{2'd2, 2'd0, 2'd1, 2'd2};

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pixel_row = '0;
    pixel_col = '0;

    // Polygon 0: (0,0),(10,0),(0,10) -> pixel (0,0),(100,0),(0,100); polygon 1 identical.
    poly_en    = 2'b01;
    background = 6'h15;
    poly_color = {6'h0C, 6'h30};
    v0_x = {7'd0, 7'd0};   v0_y = {6'd0, 6'd0};
    v1_x = {7'd10, 7'd10}; v1_y = {6'd0, 6'd0};
    v2_x = {7'd0, 7'd0};   v2_y = {6'd10, 6'd10};
    poly_depth = {3'd2, 3'd5};

    // 4-poly: p0/p2 lower-left triangle, p1/p3 upper-right triangle (100,0),(100,100),(0,100).
    poly_en4    = 4'hF;
    background4 = 6'h15;
    poly_color4 = {6'h3F, 6'h30, 6'h0C, 6'h03};
    v0_x4 = {7'd10, 7'd0, 7'd10, 7'd0}; v0_y4 = '0;
    v1_x4 = {7'd10, 7'd10, 7'd10, 7'd10}; v1_y4 = {6'd10, 6'd0, 6'd10, 6'd0};
    v2_x4 = '0;                          v2_y4 = {6'd10, 6'd10, 6'd10, 6'd10};
    poly_depth4 = {3'd2, 3'd1, 3'd2, 3'd5};

    repeat (3) @(negedge clk);
    check2("reset", 6'h00, 1'b0, 1'b0, 1'b0);
    check4("reset", 6'h00, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;

    // Single polygon, exact 2-cycle latency.
    @(negedge clk);
    pixel_col = 10'd20; pixel_row = 9'd20; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    check("single.lat1_valid", 32'(pix_valid_out), 32'd0);
    @(negedge clk);
    check2("single", 6'h30, 1'b1, 1'b1, 1'b0);

    // Depth overlap: nearer polygon 1 wins.
    poly_en    = 2'b11;
    poly_color = {6'h0C, 6'h03};
    poly_depth = {3'd2, 3'd5};
    run_px(10'd20, 9'd20, 1'b1);
    check2("depth_near", 6'h0C, 1'b1, 1'b1, 1'b1);

    // Depth tie: lowest index wins.
    poly_depth = {3'd5, 3'd5};
    run_px(10'd20, 9'd20, 1'b1);
    check2("depth_tie", 6'h03, 1'b1, 1'b1, 1'b0);

    // Miss shows background; blanked miss is black.
    run_px(10'd200, 9'd200, 1'b1);
    check2("miss", 6'h15, 1'b1, 1'b0, 1'b0);
    run_px(10'd200, 9'd200, 1'b0);
    check2("blank", 6'h00, 1'b0, 1'b0, 1'b0);

    // Enable mask: disabled polygon at depth 0 never wins.
    poly_en    = 2'b01;
    poly_depth = {3'd0, 3'd5};
    run_px(10'd20, 9'd20, 1'b1);
    check2("mask_en01", 6'h03, 1'b1, 1'b1, 1'b0);
    poly_en = 2'b00;
    run_px(10'd20, 9'd20, 1'b1);
    check2("mask_en00", 6'h15, 1'b1, 1'b0, 1'b0);

    // Streaming config for the 2-poly instance: p1 becomes the upper-right triangle.
    poly_en    = 2'b11;
    poly_depth = {3'd2, 3'd5};
    v0_x = {7'd10, 7'd0};
    v1_y = {6'd10, 6'd0};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check2($sformatf("stream2[%0d]", k - 2), e2_px[k-2], s_vld[k-2], e2_hit[k-2], e2_idx[k-2]);
        check4($sformatf("stream4[%0d]", k - 2), e4_px[k-2], s_vld[k-2], e4_hit[k-2], e4_idx[k-2]);
      end
      if (k < 4) begin
        pixel_col = s_col[k]; pixel_row = s_row[k]; pix_valid = s_vld[k];
      end else begin
        pix_valid = 1'b0;
      end
    end

    // Async reset mid-stream with pix_valid held high.
    @(negedge clk);
    pixel_col = 10'd20; pixel_row = 9'd20; pix_valid = 1'b1;
    repeat (2) @(negedge clk);
    check2("pre_reset", 6'h03, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check2("async_reset", 6'h00, 1'b0, 1'b0, 1'b0);
    check4("async_reset", 6'h00, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rel0.valid", 32'(pix_valid_out), 32'd0);
    @(negedge clk);
    check("post_rel1.valid", 32'(pix_valid_out), 32'd0);
    @(negedge clk);
    check2("post_rel2", 6'h03, 1'b1, 1'b1, 1'b0);
    pix_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
